// File: rtl/secuenciador_mem_local_rtc_pkg.sv
// Purpose: shared types and constants for the local-memory <-> RTC sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, index/address types, RTC register addresses and invalid markers.
package secuenciador_mem_local_rtc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    STORE,
    FINISH
  } state_t;

  typedef logic [3:0] idx_t;
  typedef logic [7:0] rtc_addr_t;

  // Clock/calendar block of the RTC, local indices 0..6
  localparam rtc_addr_t ADDR_SEG     = 8'h21;
  localparam rtc_addr_t ADDR_MIN     = 8'h22;
  localparam rtc_addr_t ADDR_HORA    = 8'h23;
  localparam rtc_addr_t ADDR_DIA     = 8'h24;
  localparam rtc_addr_t ADDR_MES     = 8'h25;
  localparam rtc_addr_t ADDR_DIA_SEM = 8'h26;
  localparam rtc_addr_t ADDR_ANIO    = 8'h27;

  // Timer block of the RTC, local indices 7..9
  localparam rtc_addr_t ADDR_T_SEG   = 8'h41;
  localparam rtc_addr_t ADDR_T_MIN   = 8'h42;
  localparam rtc_addr_t ADDR_T_HORA  = 8'h43;

  localparam rtc_addr_t ADDR_INVALID = 8'hFF;
  localparam idx_t      IDX_INVALID  = 4'hF;

endpackage

// File: rtl/secuenciador_mem_local_rtc_if.sv
// Purpose: bundles the control, local-memory and RTC-bus signals of the sweep sequencer.
// Latency: n/a (wiring only).
// Backpressure: bus_req is held until bus_done; the memory side has no stall.
// Modports: master = the sequencer, slave = control FSM + local memory + RTC bus driver.
interface secuenciador_mem_local_rtc_if;
  import secuenciador_mem_local_rtc_pkg::*;

  // control FSM side
  logic      start;
  logic      write_mode;
  idx_t      first_idx;
  idx_t      last_idx;
  logic      busy;
  logic      done;
  logic      error;

  // local register memory side
  idx_t      addr_mem_local;
  logic [7:0] mem_rd_data;
  logic      mem_we;
  logic [7:0] mem_wr_data;

  // RTC bus driver side
  rtc_addr_t addr_rtc;
  logic      bus_req;
  logic      bus_wr;
  logic [7:0] data_to_rtc;
  logic      bus_done;
  logic [7:0] data_from_rtc;

  modport master (
    input  start, write_mode, first_idx, last_idx,
    output busy, done, error,
    output addr_mem_local, mem_we, mem_wr_data,
    input  mem_rd_data,
    output addr_rtc, bus_req, bus_wr, data_to_rtc,
    input  bus_done, data_from_rtc
  );

  modport slave (
    output start, write_mode, first_idx, last_idx,
    input  busy, done, error,
    input  addr_mem_local, mem_we, mem_wr_data,
    output mem_rd_data,
    input  addr_rtc, bus_req, bus_wr, data_to_rtc,
    output bus_done, data_from_rtc
  );

endinterface

// File: rtl/secuenciador_mem_local_rtc_traductor.sv
// Purpose: maps a local register-memory index to its RTC register address.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_mem_local (in, 4) local index; addr_rtc (out, 8) RTC address, 8'hFF when unmapped.
module traductor_addr_mem_local_addr_rtc
  import secuenciador_mem_local_rtc_pkg::*;
(
  input  idx_t      addr_mem_local,
  output rtc_addr_t addr_rtc
);

  always_comb begin
    addr_rtc = ADDR_INVALID;
    case (addr_mem_local)
      4'd0:    addr_rtc = ADDR_SEG;
      4'd1:    addr_rtc = ADDR_MIN;
      4'd2:    addr_rtc = ADDR_HORA;
      4'd3:    addr_rtc = ADDR_DIA;
      4'd4:    addr_rtc = ADDR_MES;
      4'd5:    addr_rtc = ADDR_DIA_SEM;
      4'd6:    addr_rtc = ADDR_ANIO;
      4'd7:    addr_rtc = ADDR_T_SEG;
      4'd8:    addr_rtc = ADDR_T_MIN;
      4'd9:    addr_rtc = ADDR_T_HORA;
      default: addr_rtc = ADDR_INVALID;
    endcase
  end

endmodule

// File: rtl/secuenciador_mem_local_rtc.sv
// Purpose: sweeps local indices first..last, one RTC transaction each (write: mem->RTC, read: RTC->mem).
// Latency: per register 1 + d cycles (write) or 1 + d + 1 cycles (read), d = bus_done delay.
// Backpressure: bus_req held until bus_done or TIMEOUT_CYC cycles; start ignored unless idle.
// Ports: clk, reset (sync, active high); sif (master) carries control, local-memory and RTC-bus signals.
module secuenciador_mem_local_rtc
  import secuenciador_mem_local_rtc_pkg::*;
#(
  parameter int N_REGS      = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                          clk,
  input logic                          reset,
  secuenciador_mem_local_rtc_if.master sif
);

  localparam int                CNT_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  idx_t             idx;
  idx_t             last;
  logic             mode;
  logic [CNT_W-1:0] cnt;

  idx_t      load_idx;
  rtc_addr_t load_addr;
  logic      range_bad;
  logic      advance;

  assign range_bad = (sif.first_idx > sif.last_idx) || (int'(sif.last_idx) >= N_REGS);

  // The index for the next LOAD: first_idx when accepting a start, idx+1 when advancing.
  // Addresses are registered on the edge entering LOAD so the memory read data is ready
  // when REQ is entered.
  assign load_idx = (state == IDLE) ? sif.first_idx : idx + 4'd1;

  // A register is finished after bus_done in write mode, or after the STORE cycle in read mode.
  assign advance = ((state == REQ) && sif.bus_done && mode) || (state == STORE);

  traductor_addr_mem_local_addr_rtc u_traductor (
    .addr_mem_local (load_idx),
    .addr_rtc       (load_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      idx                <= IDX_INVALID;
      last               <= '0;
      mode               <= 1'b0;
      cnt                <= '0;
      sif.addr_mem_local <= IDX_INVALID;
      sif.addr_rtc       <= ADDR_INVALID;
      sif.mem_we         <= 1'b0;
      sif.mem_wr_data    <= '0;
      sif.bus_req        <= 1'b0;
      sif.bus_wr         <= 1'b0;
      sif.data_to_rtc    <= '0;
      sif.busy           <= 1'b0;
      sif.done           <= 1'b0;
      sif.error          <= 1'b0;
    end else begin
      sif.done   <= 1'b0;
      sif.mem_we <= 1'b0;

      case (state)
        IDLE: begin
          if (sif.start) begin
            sif.busy  <= 1'b1;
            sif.error <= 1'b0;
            if (range_bad) begin
              sif.error <= 1'b1;
              sif.done  <= 1'b1;
              state     <= FINISH;
            end else begin
              mode               <= sif.write_mode;
              last               <= sif.last_idx;
              idx                <= sif.first_idx;
              sif.addr_mem_local <= load_idx;
              sif.addr_rtc       <= load_addr;
              state              <= LOAD;
            end
          end
        end

        LOAD: begin
          if (mode) begin
            sif.data_to_rtc <= sif.mem_rd_data;
          end
          sif.bus_wr  <= mode;
          sif.bus_req <= 1'b1;
          cnt         <= '0;
          state       <= REQ;
        end

        REQ: begin
          if (sif.bus_done) begin
            sif.bus_req <= 1'b0;
            if (!mode) begin
              sif.mem_wr_data <= sif.data_from_rtc;
              sif.mem_we      <= 1'b1;
              state           <= STORE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            // Abort the whole sweep; remaining indices are skipped.
            sif.bus_req <= 1'b0;
            sif.error   <= 1'b1;
            sif.done    <= 1'b1;
            state       <= FINISH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STORE: ; // mem_we is high this cycle; the advance logic below moves on

        FINISH: begin
          sif.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (advance) begin
        if (idx == last) begin
          sif.done <= 1'b1;
          state    <= FINISH;
        end else begin
          idx                <= load_idx;
          sif.addr_mem_local <= load_idx;
          sif.addr_rtc       <= load_addr;
          state              <= LOAD;
        end
      end
    end
  end

endmodule

// File: doc/secuenciador_mem_local_rtc.md
Name: secuenciador_mem_local_rtc

Overview:
Sequencer that sweeps a range of local register-memory indices and runs one RTC bus transaction per index. It translates index to RTC address (0–6 → 0x21–0x27, 7–9 → 0x41–0x43). In write mode it copies local memory into the RTC; in read mode it copies RTC registers into local memory. It sits between the local memory, the RTC bus driver and the top-level control FSM.

Parameters:
N_REGS, 10, number of valid local indices (0..N_REGS-1)
TIMEOUT_CYC, 255, maximum cycles to wait for bus_done per transaction

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a sweep; ignored while busy
write_mode  in  1  sampled at start: 1 = mem→RTC, 0 = RTC→mem
first_idx  in  4  first local index, sampled at start
last_idx  in  4  last local index, sampled at start
addr_mem_local  out  4  local memory index (registered)
mem_rd_data  in  8  local memory read data, valid 1 cycle after addr_mem_local changes
mem_we  out  1  local memory write strobe, one cycle
mem_wr_data  out  8  local memory write data
addr_rtc  out  8  RTC register address
bus_req  out  1  transaction request, held until bus_done
bus_wr  out  1  1 = RTC write, 0 = RTC read; stable while bus_req=1
data_to_rtc  out  8  write data for the RTC
bus_done  in  1  one-cycle pulse from the RTC bus driver: transaction complete
data_from_rtc  in  8  read data, valid when bus_done=1
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at the end of a sweep, including error ends
error  out  1  sticky until next accepted start: bad range or timeout

Behaviour:
- Reset values: addr_mem_local=4'hF, addr_rtc=8'hFF, mem_we=0, mem_wr_data=0, bus_req=0, bus_wr=0, data_to_rtc=0, busy=0, done=0, error=0, state=IDLE.
- Reset mid-sweep: all outputs return to reset values at the next edge. bus_req drops with no completion and no memory write.
- FSM states: IDLE, LOAD, REQ, STORE, FINISH.
- IDLE + start:
  - Clear error.
  - If first_idx>last_idx or last_idx≥N_REGS: set error=1 and go to FINISH, with no memory or bus activity.
  - Otherwise latch the mode and range, set idx=first_idx, and go to LOAD.
- LOAD (1 cycle):
  - addr_mem_local<=idx; addr_rtc<=map(idx).
  - Next state is REQ.
- REQ:
  - On the entry edge, data_to_rtc<=mem_rd_data (write mode) and bus_wr<=mode.
  - bus_req=1 throughout REQ; the timeout counter starts at 0 on entry.
  - On bus_done=1:
    - bus_req<=0.
    - Read mode: mem_wr_data<=data_from_rtc and go to STORE.
    - Write mode: advance (see below).
  - If the counter reaches TIMEOUT_CYC without bus_done: bus_req<=0, error<=1, go to FINISH. Remaining indices are skipped.
- STORE: mem_we=1 for exactly one cycle, with addr_mem_local still equal to idx, then advance.
- Advance:
  - If idx==last: go to FINISH.
  - Otherwise idx<=idx+1 and go to LOAD. There is no wrap-around; idx never exceeds last.
- FINISH: done=1 for one cycle, busy<=0, go to IDLE. addr_mem_local and addr_rtc hold their last values.
- map(): 0..6 → 8'h21..8'h27; 7 → 8'h41; 8 → 8'h42; 9 → 8'h43; any other index → 8'hFF (unreachable after the range check).
- Ignored inputs:
  - bus_done outside REQ is ignored.
  - start while busy or in FINISH is ignored.
  - start in the same cycle as reset: reset wins.
- Timing, with bus_done arriving d cycles after bus_req rises:
  - Write mode: 1 (LOAD) + d cycles per register.
  - Read mode: 1 + d + 1 (STORE) cycles per register.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - RTC address constants (ADDR_SEG=8'h21 … ADDR_ANIO=8'h27, ADDR_T_SEG=8'h41 … ADDR_T_HORA=8'h43).
  - ADDR_INVALID=8'hFF and IDX_INVALID=4'hF.
- One combinational sub-module, traductor_addr_mem_local_addr_rtc, implements the index→RTC address map. It is the inverse of the existing RTC→local translator and is shared with it for checks.

Test Plan:
- Full write sweep: first=0, last=9, write_mode=1, mem[i]=8'h10+i, bus_done 3 cycles after each req.
  → Ten transactions with addr_rtc 21,22,…,27,41,42,43, data_to_rtc 10..19 and bus_wr=1.
  → One done pulse; mem_we never asserted.
- Read sweep: first=7, last=9, write_mode=0, data_from_rtc=8'hA0+idx.
  → mem_we pulses at addr_mem_local 7,8,9 with data A7,A8,A9.
  → bus_wr=0; done pulses; error=0.
- Bad range: first=5, last=3, then first=0, last=10.
  → Each gives error=1 and one done pulse, with no bus_req and no mem_we.
- Timeout: bus_done never asserted at first=0.
  → bus_req drops after 255 cycles; error=1; done pulses; addr_rtc=8'h21; no later transactions.
- Reset mid-REQ at idx 4, then start again without reset.
  → All outputs return to reset values (addr_mem_local=4'hF, addr_rtc=8'hFF) on the next edge.
  → A new start runs normally from first_idx.
- Ignored events: start pulsed while busy, and bus_done pulsed in IDLE.
  → No effect on the sweep: index order, count and done timing are unchanged.
